bcd2bin_seq: RTL and testbench

Sequential reverse double-dabble converter, the inverse of the binary-to-BCD/7-segment path. Takes a two-digit BCD value (tens, ones) and produces the unsigned binary equivalent through iterative shift-right / subtract-3. Used where keypad or display-domain decimal values must go back into binary datapaths. Start/busy/done handshake; one bit resolved per clock.

---
 rtl/bcd2bin_seq_if.sv | 37 +++
 rtl/bcd2bin_seq.sv | 137 +++++++++++++
 tb/tb_bcd2bin_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_seq_if.sv
// ============================================================================
// Module   : bcd2bin_seq_if
// Brief    : Start/busy/done handshake bundle for the BCD-to-binary converter.
//            Digit width follows BCD2BIN_7SEG_IN_EN (7-bit segments vs 4-bit BCD).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bcd2bin_seq_if #(
    parameter int BIN_W = 7
);
`ifdef BCD2BIN_7SEG_IN_EN
    localparam int DIG_W = 7;
`else
    localparam int DIG_W = 4;
`endif

    logic             in_start;
    logic [DIG_W-1:0] in_T;
    logic [DIG_W-1:0] in_O;
    logic [BIN_W-1:0] out_Bin;
    logic             out_busy;
    logic             out_done;
    logic             out_err;

    modport master (
        output in_start, in_T, in_O,
        input  out_Bin, out_busy, out_done, out_err
    );

    modport slave (
        input  in_start, in_T, in_O,
        output out_Bin, out_busy, out_done, out_err
    );
endinterface

`default_nettype wire

// File: rtl/bcd2bin_seq.sv
// ============================================================================
// Module   : bcd2bin_seq
// Brief    : Two-digit BCD to binary via reverse double-dabble, one bit per clock.
//            Define BCD2BIN_7SEG_IN_EN to accept active-low 7-segment digit codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd2bin_seq #(
    parameter int BIN_W = 7
) (
    input  wire logic      clk,
    input  wire logic      rst,
    bcd2bin_seq_if.slave   bus
);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam int                 c_CNT_W = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BIN_W - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [7:0]         r_bcd;
    logic [7:0]         w_bcd_shift;
    logic [7:0]         w_bcd_next;
    logic [BIN_W-1:0]   r_bin;
    logic [BIN_W-1:0]   w_bin_next;
    logic [BIN_W-1:0]   r_out_bin;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;
    logic               r_out_err;
    logic               w_last;
    logic [3:0]         w_dig_t;
    logic [3:0]         w_dig_o;
    logic               w_dig_err;

`ifdef BCD2BIN_7SEG_IN_EN
    // Returns {invalid, digit}; unknown patterns decode to digit 0 with invalid set.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h40:   return 5'h00;
            7'h79:   return 5'h01;
            7'h24:   return 5'h02;
            7'h30:   return 5'h03;
            7'h19:   return 5'h04;
            7'h12:   return 5'h05;
            7'h02:   return 5'h06;
            7'h78:   return 5'h07;
            7'h00:   return 5'h08;
            7'h10:   return 5'h09;
            default: return 5'h10;
        endcase
    endfunction

    logic [4:0] w_dec_t;
    logic [4:0] w_dec_o;

    assign w_dec_t   = seg_decode(bus.in_T);
    assign w_dec_o   = seg_decode(bus.in_O);
    assign w_dig_t   = w_dec_t[3:0];
    assign w_dig_o   = w_dec_o[3:0];
    assign w_dig_err = w_dec_t[4] | w_dec_o[4];
`else
    assign w_dig_t   = bus.in_T;
    assign w_dig_o   = bus.in_O;
    assign w_dig_err = (bus.in_T > 4'd9) | (bus.in_O > 4'd9);
`endif

    // One iteration: shift the BCD LSB into the binary MSB, then correct digits >= 8.
    assign {w_bcd_shift, w_bin_next} = {r_bcd, r_bin} >> 1;
    assign w_bcd_next[7:4] = (w_bcd_shift[7:4] >= 4'd8) ? w_bcd_shift[7:4] - 4'd3 : w_bcd_shift[7:4];
    assign w_bcd_next[3:0] = (w_bcd_shift[3:0] >= 4'd8) ? w_bcd_shift[3:0] - 4'd3 : w_bcd_shift[3:0];
    assign w_last          = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.in_start) w_state_next = c_ST_SHIFT;
            c_ST_SHIFT: if (w_last)       w_state_next = c_ST_DONE;
            c_ST_DONE:                    w_state_next = c_ST_IDLE;
            default:                      w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        bus.out_busy = (r_state == c_ST_SHIFT);
        bus.out_done = (r_state == c_ST_DONE);
        bus.out_Bin  = r_out_bin;
        bus.out_err  = r_out_err;
    end

    // Result registers load on the final shift edge so they are valid during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_out_bin <= '0;
            r_out_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.in_start) begin
                        r_bcd     <= {w_dig_t, w_dig_o};
                        r_bin     <= '0;
                        r_cnt     <= '0;
                        r_err     <= w_dig_err;
                        r_out_err <= 1'b0;
                    end
                end
                c_ST_SHIFT: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= w_bin_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out_bin <= w_bin_next;
                        r_out_err <= r_err | (w_bcd_next != 8'd0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
// ============================================================================
// Module   : tb_bcd2bin_seq
// Brief    : Scoreboard bench for bcd2bin_seq (BIN_W=7 main instance, BIN_W=6 overflow instance).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd2bin_seq;
    localparam int BIN_W  = 7;
    localparam int BIN_W6 = 6;
`ifdef BCD2BIN_7SEG_IN_EN
    localparam int DIG_W = 7;
`else
    localparam int DIG_W = 4;
`endif

    typedef struct {
        int bin;
        bit err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd2bin_seq_if #(.BIN_W(BIN_W))  bus  ();
    bcd2bin_seq_if #(.BIN_W(BIN_W6)) bus6 ();

    bcd2bin_seq #(.BIN_W(BIN_W))  dut  (.clk(clk), .rst(rst), .bus(bus));
    bcd2bin_seq #(.BIN_W(BIN_W6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   busy_cnt = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [DIG_W-1:0] enc(input int d);
`ifdef BCD2BIN_7SEG_IN_EN
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
`else
        return DIG_W'(d);
`endif
    endfunction

    function automatic exp_t model(input int t, input int o, input int w);
        exp_t e;
        e.err = (t > 9) || (o > 9);
        e.bin = t * 10 + o;
        if (!e.err && e.bin >= (1 << w)) e.err = 1'b1;
        return e;
    endfunction

    task automatic drive(input int t, input int o);
        bus.in_T = enc(t);
        bus.in_O = enc(o);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.out_done) return;
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic convert(input int t, input int o);
        int lat;
        sb.push_back(model(t, o, BIN_W));
        @(posedge clk); #1;
        drive(t, o);
        bus.in_start = 1'b1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        drive(9, 8);  // must not leak into the running conversion
        wait_done(lat);
        check("latency", lat, BIN_W + 1);
    endtask

    task automatic convert6(input int t, input int o);
        exp_t e;
        bit   seen;
        e    = model(t, o, BIN_W6);
        seen = 1'b0;
        @(posedge clk); #1;
        bus6.in_T     = enc(t);
        bus6.in_O     = enc(o);
        bus6.in_start = 1'b1;
        @(posedge clk); #1;
        bus6.in_start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus6.out_done) seen = 1'b1;
        end
        check("w6_done_seen", int'(seen), 1);
        check("w6_err", int'(bus6.out_err), int'(e.err));
        if (!e.err) check("w6_bin", int'(bus6.out_Bin), e.bin);
    endtask

    // Scoreboard monitor on the main instance
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (bus.out_busy) busy_cnt++;
            if (bus.out_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("err", int'(bus.out_err), int'(mon_e.err));
                    if (!mon_e.err) check("bin", int'(bus.out_Bin), mon_e.bin);
                    check("busy_cycles", busy_cnt, BIN_W);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dones;

        bus.in_start  = 1'b0;
        bus6.in_start = 1'b0;
        drive(0, 0);
        bus6.in_T = enc(0);
        bus6.in_O = enc(0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_bin",  int'(bus.out_Bin),  0);
        check("rst_busy", int'(bus.out_busy), 0);
        check("rst_done", int'(bus.out_done), 0);
        check("rst_err",  int'(bus.out_err),  0);

        convert(2, 3);
        convert(4, 1);
        convert(0, 0);
        convert(5, 9);
        convert(9, 9);

        // Invalid digit then recovery
        convert(1, 10);
        convert(0, 7);

        // Reset in the third busy cycle aborts without a done pulse
        @(posedge clk); #1;
        drive(2, 3);
        bus.in_start = 1'b1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_bin",  int'(bus.out_Bin),  0);
        check("abort_busy", int'(bus.out_busy), 0);
        check("abort_err",  int'(bus.out_err),  0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_done) dones++;
        end
        check("abort_no_done", dones, 0);

        // Start pulsed mid-busy and in the DONE cycle is ignored
        sb.push_back(model(3, 4, BIN_W));
        @(posedge clk); #1;
        drive(3, 4);
        bus.in_start = 1'b1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.in_start = 1'b1;
        drive(8, 8);
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        wait_done(lat);
        bus.in_start = 1'b1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_done) dones++;
        end
        check("ignored_start", dones, 0);

        // Start held high: one conversion every 9 cycles using inputs at acceptance
        sb.push_back(model(1, 2, BIN_W));
        @(posedge clk); #1;
        drive(1, 2);
        bus.in_start = 1'b1;
        wait_done(lat);
        sb.push_back(model(6, 7, BIN_W));
        drive(6, 7);
        wait_done(lat);
        check("held_period", lat, 9);
        sb.push_back(model(8, 0, BIN_W));
        drive(8, 0);
        wait_done(lat);
        check("held_period", lat, 9);
        sb.push_back(model(9, 9, BIN_W));
        drive(9, 9);
        wait_done(lat);
        check("held_period", lat, 9);
        bus.in_start = 1'b0;

        // Overflow on the narrow instance
        convert6(9, 9);
        convert6(6, 3);
        convert6(4, 2);

        repeat (12) @(posedge clk);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
